// File: rtl/irq_ctrl.sv
// irq_ctrl: priority interrupt controller with mask/pending/current registers and a PEND/SERVICE handshake.
// Define IRQ_CTRL_SYNC_EN to put a 2-flop synchronizer on every src_irq bit (adds two edges of latency).
module irq_ctrl #(
    parameter int NSRC = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src_irq,
    input  logic [1:0]      addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    input  logic            ack,
    output logic            irq_out,
    output logic [2:0]      irq_id
);
    typedef enum logic [1:0] {IDLE, PEND, SERVICE} state_t;
    state_t state, state_nxt;
    logic [NSRC-1:0] mask, pending, src_q, src_s, rise, clr, act_vec, pending_nxt, mask_nxt;
    logic [2:0] cur_id, req_id;
    logic take, eoi;
`ifdef IRQ_CTRL_SYNC_EN
    logic [NSRC-1:0] sync1, sync2;
    always_ff @(posedge clk or negedge reset)
        if (!reset) {sync2, sync1} <= '0;
        else {sync2, sync1} <= {sync1, src_irq};
    assign src_s = sync2;
`else
    assign src_s = src_irq;
`endif
    assign rise        = src_s & ~src_q;
    assign take        = state == PEND && ack;
    assign eoi         = we && addr == 2'd3;
    assign act_vec     = pending & mask;
    // a rising edge in the same cycle as a clear wins, so no event is lost
    assign clr         = (we && addr == 2'd1 ? wdata[NSRC-1:0] : '0) | (take ? NSRC'(1) << req_id : '0);
    assign pending_nxt = (pending & ~clr) | rise;
    assign mask_nxt    = we && addr == 2'd0 ? wdata[NSRC-1:0] : mask;
    always_comb begin
        req_id = '0;
        for (int i = NSRC - 1; i >= 0; i--)
            if (act_vec[i]) req_id = 3'(i);
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else state <= state_nxt;
    // PEND drops as soon as the request vanishes, so irq_out never points at a stale source
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = |act_vec ? PEND : IDLE;
            PEND:    state_nxt = take ? SERVICE : (|(pending_nxt & mask_nxt) ? PEND : IDLE);
            SERVICE: state_nxt = eoi ? IDLE : SERVICE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        irq_out = state == PEND;
        irq_id  = state == PEND ? req_id : state == SERVICE ? cur_id : '0;
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            mask    <= '0;
            pending <= '0;
            src_q   <= '0;
            cur_id  <= '0;
        end else begin
            mask    <= mask_nxt;
            pending <= pending_nxt;
            src_q   <= src_s;
            if (take) cur_id <= req_id;
        end
    always_comb
        rdata = addr == 2'd0 ? 32'(mask) : addr == 2'd1 ? 32'(pending) : addr == 2'd2 ? {29'b0, cur_id} : '0;
endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL provide parameter: NSRC, 6, number of interrupt sources (1..8).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-low (0 = reset asserted).
REQ-004 SHALL provide port: src_irq  input  NSRC  level interrupt sources (bit0 = TC0 IRQ, bit1 = TC1 IRQ, bit2 = external interrupt, rest spare).
REQ-005 SHALL provide port: addr  input  2  register select (word address bits [3:2]).
REQ-006 SHALL provide port: we  input  1  register write strobe, one cycle.
REQ-007 SHALL provide port: wdata  input  32  register write data.
REQ-008 SHALL provide port: rdata  output  32  register read data, combinational from addr.
REQ-009 SHALL provide port: ack  input  1  CPU exception-entry pulse, one cycle.
REQ-010 SHALL provide port: irq_out  output  1  interrupt request to CPU HWInt.
REQ-011 SHALL provide port: irq_id  output  3  index of the source being requested/serviced.

Function
REQ-012 SHALL map registers: 0 MASK (RW, bits [NSRC-1:0], 1 = enabled); 1 PENDING (R; write-1-to-clear); 2 CURRENT (R, {29'b0, cur_id}); 3 EOI (W, any data).
REQ-013 SHALL keep src_q (previous sample per source) and set pending[i] at the edge where src_irq[i]=1 and src_q[i]=0 (rising-edge capture).
REQ-014 SHALL select req_id = lowest index i with pending[i] & mask[i]; bit 0 highest priority.
REQ-015 SHALL implement FSM IDLE, PEND, SERVICE; irq_out = (state == PEND); irq_id = req_id in PEND, cur_id in SERVICE, 0 in IDLE.
REQ-016 IDLE -> PEND on next edge when any (pending & mask) != 0.
REQ-017 PEND -> SERVICE on edge with ack=1: cur_id <= req_id, pending[req_id] cleared same edge.
REQ-018 PEND -> IDLE on edge where (pending & mask) becomes 0 without ack (masked or cleared by software); irq_out withdrawn.
REQ-019 SERVICE -> IDLE on edge with we=1 and addr=3; EOI in IDLE or PEND ignored.
REQ-020 ack outside PEND SHALL be ignored.
REQ-021 Latency: src_irq rising before edge k -> pending at k -> irq_out high after edge k+1 (2 edges).
REQ-022 Simultaneous set and clear (W1C or ack clear) of same pending bit SHALL resolve to set.
REQ-023 New edges during SERVICE SHALL latch in pending and be requested after EOI; no nesting.
REQ-024 Source held high SHALL produce exactly one pending event until it falls and rises again.
REQ-025 MASK writes SHALL not clear pending bits; masked pending bits SHALL remain readable.

Reset
REQ-026 reset=0 SHALL asynchronously force state=IDLE, mask=0, pending=0, src_q=0, cur_id=0, sync flops=0; hence irq_out=0, irq_id=0.
REQ-027 Reset mid-PEND or mid-SERVICE SHALL drop irq_out immediately and discard all pending events; a source high at reset release SHALL register as a rising edge.

Configuration
REQ-028 Macro IRQ_CTRL_SYNC_EN defined: each src_irq bit passes a 2-flop synchronizer before edge detection; REQ-021 latency becomes 4 edges.
REQ-029 IRQ_CTRL_SYNC_EN undefined: src_irq used directly; latency 2 edges; no other behavioural difference.

Verification
REQ-030 MASK=0x7, pulse src_irq=0x2 -> irq_out=1, irq_id=1 two edges later; ack -> SERVICE, PENDING=0x0, CURRENT=1; EOI -> IDLE.
REQ-031 MASK=0x7, src_irq=0x6 same cycle -> irq_id=1 served first; after EOI, irq_out=1 with irq_id=2 within 1 edge.
REQ-032 MASK=0x0, src_irq rise on bit0 -> PENDING=0x1, irq_out=0; write MASK=0x1 -> irq_out=1 one edge later; write PENDING=0x1 before ack -> irq_out=0, state IDLE.
REQ-033 In SERVICE (cur_id=0), src_irq bit0 re-rises -> PENDING=0x1, irq_out=0 until EOI, then irq_out=1, irq_id=0.
REQ-034 W1C of bit2 in same cycle as bit2 rising edge -> PENDING bit2 reads 1 afterward.
REQ-035 reset=0 asserted while irq_out=1 -> irq_out=0 without clock edge; after release with src_irq=0x1, MASK=0 -> irq_out stays 0, PENDING=0x1.
